// File: rtl/debug_regfile_dump_sequencer.sv
// Debug-unit register file dump: walks addresses 0..N_REGS-1, captures each returned
// word and presents it as a frame on a valid/ready handshake, with abort support.
//
// state   | meaning
// IDLE    | waiting for i_start; select parked on the non-regfile code
// ISSUE   | o_reg_addr / o_request_select drive the current address
// CAPTURE | regfile word is valid; latch it with its index
// SEND    | o_frame_valid high until i_frame_ready
// DONE    | one-cycle o_done pulse after the last frame is accepted
module debug_regfile_dump_sequencer #(
    parameter int NB_DATA       = 32,
    parameter int NB_ADDR       = 5,
    parameter int N_REGS        = 32,
    parameter int NB_REQ_SELECT = 6
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_abort,
    output logic [NB_REQ_SELECT-1:0] o_request_select,
    output logic [NB_ADDR-1:0]       o_reg_addr,
    input  logic [NB_DATA-1:0]       i_reg_data,
    output logic [NB_DATA-1:0]       o_frame,
    output logic [NB_ADDR-1:0]       o_frame_index,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

    state_t                   state;
    state_t                   state_next;
    logic [NB_ADDR-1:0]       addr;
    logic [NB_ADDR-1:0]       addr_next;
    logic [NB_REQ_SELECT-2:0] sel_addr;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            addr  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
        end
    end

    // Abort outranks everything, including a handshake in the same cycle.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        if (state != ST_IDLE && i_abort) begin
            state_next = ST_IDLE;
            addr_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_next = ST_ISSUE;
                        addr_next  = '0;
                    end
                end
                ST_ISSUE:   state_next = ST_CAPTURE;
                ST_CAPTURE: state_next = ST_SEND;
                ST_SEND: begin
                    if (i_frame_ready) begin
                        if (addr == LAST_ADDR) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_ISSUE;
                            addr_next  = addr + NB_ADDR'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end
            endcase
        end
    end

    assign sel_addr   = (NB_REQ_SELECT - 1)'(addr);
    assign o_reg_addr = addr;

    always_comb begin
        o_frame_valid    = (state == ST_SEND);
        o_busy           = (state != ST_IDLE);
        o_done           = (state == ST_DONE);
        o_request_select = '0;
        if (state != ST_IDLE) begin
            o_request_select = {1'b0, sel_addr};
        end else begin
            o_request_select[NB_REQ_SELECT-1] = 1'b1;
        end
    end

    // Frame holds from CAPTURE until the next capture, so it is stable across SEND.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_frame       <= '0;
            o_frame_index <= '0;
        end else if (state == ST_CAPTURE && !i_abort) begin
            o_frame       <= i_reg_data;
            o_frame_index <= addr;
        end
    end

endmodule
